// File: rtl/router_pkg.sv
// Shared flit encodings and the input-buffer state type for the router.
package router_pkg;

  localparam logic [2:0] FLIT_NONE   = 3'b000;
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  localparam int LEN_W = 12;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } inbuf_state_t;

endpackage

// File: rtl/inbuf_fifo.sv
// Synchronous FIFO with async active-high reset. It refuses a push when full and ignores a pop when empty.
module inbuf_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/router_input_buffer.sv
// Per-direction router input stage: flit FIFO, head decode and whole-packet request FSM.
// Optional sticky protocol checker enabled by defining ROUTER_INBUF_ERRCHK_EN.
module router_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int LEN_W      = router_pkg::LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2:0]            in_flit_id,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  grant,
  output logic                  req,
  output logic [2:0]            flit_id,
  output logic [LEN_W-1:0]      length,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err
);

  import router_pkg::*;

  localparam int EW = DATA_WIDTH + 3;

  logic [EW-1:0]         head_s;
  logic [2:0]            head_id_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  full_s, empty_s;
  logic                  push_s, pop_s;
  inbuf_state_t          state_q, state_d;

  assign push_s = in_valid && !full_s;
  // A non-header at the head while idle is never popped, so a bad packet stalls here.
  assign pop_s  = grant && !empty_s && ((state_q == ACTIVE) || (head_id_s == FLIT_HEADER));

  inbuf_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_s),
    .wr_data_i ({in_flit_id, in_data}),
    .pop_i     (pop_s),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  assign head_id_s   = empty_s ? FLIT_NONE : head_s[EW-1:DATA_WIDTH];
  assign head_data_s = empty_s ? '0 : head_s[DATA_WIDTH-1:0];

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign flit_id   = head_id_s;
  assign out_data  = head_data_s;
  assign length    = head_data_s[LEN_W-1:0];
  assign req       = (state_q == ACTIVE) || (head_id_s == FLIT_HEADER);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop_s && (head_id_s == FLIT_HEADER)) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (pop_s && (head_id_s == FLIT_TAIL)) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ROUTER_INBUF_ERRCHK_EN
  logic err_q, err_d;
  logic wr_open_q, wr_open_d;

  // wr_open tracks whether the upstream side is still inside a packet (header seen, tail not yet).
  always_comb begin
    wr_open_d = wr_open_q;
    err_d     = err_q;
    if (push_s && (in_flit_id == FLIT_HEADER)) begin
      wr_open_d = 1'b1;
    end else if (push_s && (in_flit_id == FLIT_TAIL)) begin
      wr_open_d = 1'b0;
    end else begin
      wr_open_d = wr_open_q;
    end
    if ((in_valid && full_s) ||
        ((state_q == IDLE) && !empty_s && (head_id_s != FLIT_HEADER)) ||
        (push_s && (in_flit_id == FLIT_HEADER) && wr_open_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      wr_open_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      wr_open_q <= wr_open_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Scoreboard bench for router_input_buffer: expected flits are queued on accepted pushes and compared when popped.
module tb_router_input_buffer;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
`ifdef ROUTER_INBUF_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_flit_id;
  logic [31:0] in_data;
  logic        in_ready;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        out_valid;
  logic [31:0] out_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [34:0] sb[$];
  logic        m_active;
  logic        m_wopen;
  logic        m_err;

  always #5 clk = ~clk;

  router_input_buffer #(.DATA_WIDTH(32), .DEPTH(8), .LEN_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit_id (in_flit_id),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .grant      (grant),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [34:0] h;
    h = (sb.size() != 0) ? sb[0] : 35'd0;
    check_eq("in_ready",  64'(in_ready),  64'(sb.size() < 8));
    check_eq("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check_eq("flit_id",   64'(flit_id),   64'(h[34:32]));
    check_eq("out_data",  64'(out_data),  64'(h[31:0]));
    check_eq("length",    64'(length),    64'(h[11:0]));
    check_eq("req",       64'(req),       64'(m_active || (h[34:32] == HDR)));
    check_eq("err",       64'(err),       64'(ERRCHK && m_err));
  endtask

  task automatic model_clear();
    sb.delete();
    m_active = 1'b0;
    m_wopen  = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock: check outputs, drive inputs, advance the model at the edge.
  task automatic cycle(input logic v, input logic [2:0] id, input logic [31:0] d, input logic g);
    logic [34:0] h;
    logic        do_push, do_pop, err_n;
    check_outputs();
    in_valid = v; in_flit_id = id; in_data = d; grant = g;
    h       = (sb.size() != 0) ? sb[0] : 35'd0;
    do_push = v && (sb.size() < 8);
    do_pop  = g && (sb.size() != 0) && (m_active || (h[34:32] == HDR));
    err_n   = (v && (sb.size() == 8)) ||
              (!m_active && (sb.size() != 0) && (h[34:32] != HDR)) ||
              (do_push && (id == HDR) && m_wopen);
    @(posedge clk);
    if (do_pop) begin
      check_eq("pop_data", 64'(out_data), 64'(h[31:0]));
      void'(sb.pop_front());
      if (h[34:32] == HDR) m_active = 1'b1;
      else if (h[34:32] == TAIL) m_active = 1'b0;
    end
    if (do_push) begin
      sb.push_back({id, d});
      if (id == HDR) m_wopen = 1'b1;
      else if (id == TAIL) m_wopen = 1'b0;
    end
    if (err_n) m_err = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'b000, 32'd0, g);
  endtask

  // Async reset between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_req",       64'(req),       64'd0);
    check_eq("rst_flit_id",   64'(flit_id),   64'd0);
    check_eq("rst_length",    64'(length),    64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_err",       64'(err),       64'd0);
    in_valid = 1'b0; grant = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit_id = 3'b000; in_data = 32'd0; grant = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Packet header(len=5) + 2 body + tail with grant held.
    cycle(1'b1, HDR,  32'hA000_0005, 1'b1);
    cycle(1'b1, BODY, 32'hB000_0011, 1'b1);
    cycle(1'b1, BODY, 32'hB000_0022, 1'b1);
    cycle(1'b1, TAIL, 32'hC000_0033, 1'b1);
    idle(3, 1'b1);

    // Fill to DEPTH with no grant; the 9th flit is dropped, then drain in order.
    cycle(1'b1, HDR, 32'h0000_0123, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, BODY, 32'h1000_0000 + 32'(i), 1'b0);
    cycle(1'b1, TAIL, 32'h2000_0007, 1'b0);
    cycle(1'b1, HDR,  32'h3000_0999, 1'b0);
    idle(10, 1'b1);

    // Grant withdrawn mid-packet for three cycles.
    cycle(1'b1, HDR, 32'h4000_0004, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, BODY, 32'h5000_0000 + 32'(i), 1'b0);
    cycle(1'b1, TAIL, 32'h6000_0000, 1'b0);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Upstream gap: FIFO empty while the packet is still open.
    cycle(1'b1, HDR, 32'h7000_0003, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, BODY, 32'h8000_0001, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, TAIL, 32'h9000_0002, 1'b1);
    idle(2, 1'b1);

    // Random back-to-back packets with random grant.
    for (int p = 0; p < 6; p++) begin
      int nb;
      nb = $urandom_range(0, 3);
      cycle(1'b1, HDR, 32'(nb + 2), 1'($urandom_range(0, 1)));
      for (int b = 0; b < nb; b++) cycle(1'b1, BODY, $urandom, 1'($urandom_range(0, 1)));
      cycle(1'b1, TAIL, $urandom, 1'($urandom_range(0, 1)));
    end
    idle(20, 1'b1);

    // Reset mid-traffic.
    cycle(1'b1, HDR,  32'hD000_0006, 1'b0);
    cycle(1'b1, BODY, 32'hD000_0001, 1'b0);
    async_reset();
    check_outputs();

    // Body into an empty idle buffer: stalls, flagged when the checker is built in.
    cycle(1'b1, BODY, 32'hE000_0001, 1'b0);
    idle(4, 1'b1);
    async_reset();
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
